// File: rtl/phase_rotator_if.sv
// Bus between the CDR lock/phase-detector logic and the phase rotator.
// The phase detector's early/late requests and the load port drive the rotator.
// The rotator returns the one-hot phase, its binary index and the status strobes.
interface phase_rotator_if #(
  parameter int N_PHASES = 8,
  parameter int DRIFT_W  = 8
);
  localparam int IDX_W = (N_PHASES <= 2) ? 1 : $clog2(N_PHASES);

  logic                en;
  logic                adv;
  logic                ret;
  logic                ld;
  logic [IDX_W-1:0]    ld_idx;
  logic [N_PHASES-1:0] phase;
  logic [IDX_W-1:0]    phase_idx;
  logic                wrap;
  logic                corr_ack;
  logic                ld_err;
  logic [DRIFT_W-1:0]  drift;

  // Side that owns the control inputs: the lock logic or a testbench.
  modport master (
    output en, adv, ret, ld, ld_idx,
    input  phase, phase_idx, wrap, corr_ack, ld_err, drift
  );

  // Side that owns the rotator state: the phase_rotator itself.
  modport slave (
    input  en, adv, ret, ld, ld_idx,
    output phase, phase_idx, wrap, corr_ack, ld_err, drift
  );
endinterface

// File: rtl/phase_rotator.sv
// N-phase one-hot clock-phase generator with early/late correction for the CDR.
// Nominal rotation is one phase per enabled clock. An accepted late request (adv)
// steps two phases, and an accepted early request (ret) holds the phase.
// After an accepted correction, further requests are ignored for HOLDOFF cycles.
// drift is a signed, saturating count of the net accepted corrections.
module phase_rotator #(
  parameter int N_PHASES = 8,
  parameter int HOLDOFF  = 4,
  parameter int DRIFT_W  = 8
) (
  input logic          clk,
  input logic          rst,
  phase_rotator_if.slave bus
);

  localparam int IDX_W = (N_PHASES <= 2) ? 1 : $clog2(N_PHASES);
  localparam int HO_W  = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  // N_PHASES carried with one extra bit so that idx + 2 and the modulus compare cleanly.
  localparam logic [IDX_W:0]   N_EXT     = (IDX_W + 1)'(N_PHASES);
  localparam logic [HO_W-1:0]  HOLD_LOAD = HO_W'(HOLDOFF);
  localparam logic [DRIFT_W-1:0] DRIFT_MAX = {1'b0, {(DRIFT_W - 1){1'b1}}};
  localparam logic [DRIFT_W-1:0] DRIFT_MIN = {1'b1, {(DRIFT_W - 1){1'b0}}};

  // Registered state; every output comes straight from one of these.
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic [N_PHASES-1:0] phase_q, phase_d;
  logic                wrap_q,  wrap_d;
  logic                ack_q,   ack_d;
  logic                err_q,   err_d;
  logic [DRIFT_W-1:0]  drift_q, drift_d;
  logic [HO_W-1:0]     hold_q,  hold_d;

  // Per-cycle decode.
  logic             ld_ok;
  logic             accept;
  logic [1:0]       step;
  logic [IDX_W:0]   sum;
  logic             rot_wrap;
  logic [IDX_W:0]   rot_full;
  logic [IDX_W-1:0] rot_idx;

  // Decode load validity and correction acceptance, and compute the rotated index.
  always_comb begin
    ld_ok  = bus.ld && ({1'b0, bus.ld_idx} < N_EXT);
    // A request is honoured only when exactly one of adv/ret is high.
    // The rotator must be enabled, no valid load may be pending, and holdoff must be over.
    accept = bus.en && !ld_ok && (bus.adv ^ bus.ret) && (hold_q == '0);

    step = 2'd1;
    if (accept) begin
      step = bus.adv ? 2'd2 : 2'd0;
    end

    // step <= 2 < 2*N, so one conditional subtraction gives the modulo result.
    sum      = {1'b0, idx_q} + (IDX_W + 1)'(step);
    rot_wrap = (sum >= N_EXT);
    rot_full = rot_wrap ? (sum - N_EXT) : sum;
    rot_idx  = rot_full[IDX_W-1:0];
  end

  // Next-state selection: a valid load has priority over enabled rotation.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    ack_d   = 1'b0;
    err_d   = bus.ld && !ld_ok;
    drift_d = drift_q;
    hold_d  = (hold_q != '0) ? (hold_q - HO_W'(1)) : hold_q;

    if (ld_ok) begin
      idx_d  = bus.ld_idx;
      hold_d = '0;
    end else if (bus.en) begin
      idx_d  = rot_idx;
      wrap_d = rot_wrap;
      if (accept) begin
        ack_d  = 1'b1;
        hold_d = HOLD_LOAD;
        if (bus.adv) begin
          if (drift_q != DRIFT_MAX) drift_d = drift_q + DRIFT_W'(1);
        end else begin
          if (drift_q != DRIFT_MIN) drift_d = drift_q - DRIFT_W'(1);
        end
      end
    end

    // idx_d is always below N_PHASES, so exactly one bit is set.
    phase_d        = '0;
    phase_d[idx_d] = 1'b1;
  end

  // State register; an asynchronous reset returns the rotator to phase 0 at any time.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: reset is asynchronous and covers every register here, so outputs are defined immediately in reset.
    if (rst) begin
      idx_q   <= '0;
      phase_q <= N_PHASES'(1);
      wrap_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      drift_q <= '0;
      hold_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments, so all registers update together from the same pre-edge values.
      idx_q   <= idx_d;
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      drift_q <= drift_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.phase     = phase_q;
  assign bus.phase_idx = idx_q;
  assign bus.wrap      = wrap_q;
  assign bus.corr_ack  = ack_q;
  assign bus.ld_err    = err_q;
  assign bus.drift     = drift_q;

  // The phase vector is one-hot and matches the binary index.
  a_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot(phase_q) && phase_q[idx_q]);

endmodule

// File: tb/tb_phase_rotator.sv
// Directed testbench for phase_rotator.
// Four instances cover N=8 with holdoff, N=6, a 3-bit saturating drift counter, and N=2.
module tb_phase_rotator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  phase_rotator_if #(.N_PHASES(8), .DRIFT_W(8)) a_if ();
  phase_rotator_if #(.N_PHASES(6), .DRIFT_W(8)) b_if ();
  phase_rotator_if #(.N_PHASES(8), .DRIFT_W(3)) c_if ();
  phase_rotator_if #(.N_PHASES(2), .DRIFT_W(8)) d_if ();

  phase_rotator #(.N_PHASES(8), .HOLDOFF(4), .DRIFT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  phase_rotator #(.N_PHASES(6), .HOLDOFF(4), .DRIFT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(b_if));
  phase_rotator #(.N_PHASES(8), .HOLDOFF(0), .DRIFT_W(3)) dut_c (.clk(clk), .rst(rst), .bus(c_if));
  phase_rotator #(.N_PHASES(2), .HOLDOFF(0), .DRIFT_W(8)) dut_d (.clk(clk), .rst(rst), .bus(d_if));

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_if.en = 0; a_if.adv = 0; a_if.ret = 0; a_if.ld = 0; a_if.ld_idx = '0;
    b_if.en = 0; b_if.adv = 0; b_if.ret = 0; b_if.ld = 0; b_if.ld_idx = '0;
    c_if.en = 0; c_if.adv = 0; c_if.ret = 0; c_if.ld = 0; c_if.ld_idx = '0;
    d_if.en = 0; d_if.adv = 0; d_if.ret = 0; d_if.ld = 0; d_if.ld_idx = '0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reset values, then free-run at N=8: one wrap per 8 clocks on 7->0.
  task automatic test_reset_and_rotate();
    int wraps;
    logic [7:0] exp_ph;
    do_reset();
    total++;
    if (a_if.phase_idx !== 3'd0 || a_if.phase !== 8'h01 || a_if.wrap !== 1'b0 ||
        a_if.corr_ack !== 1'b0 || a_if.ld_err !== 1'b0 || a_if.drift !== 8'd0) begin
      bad++;
      $display("FAIL reset_state: idx=%0d phase=%h wrap=%b ack=%b err=%b drift=%0d want idx=0 phase=01 rest 0",
               a_if.phase_idx, a_if.phase, a_if.wrap, a_if.corr_ack, a_if.ld_err, a_if.drift);
    end
    wraps = 0;
    a_if.en = 1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp_ph = 8'd1 << (i % 8);
      if (a_if.wrap === 1'b1) wraps++;
      total++;
      if (a_if.phase_idx !== 3'(i % 8) || a_if.phase !== exp_ph ||
          a_if.wrap !== (i % 8 == 0) || a_if.drift !== 8'd0) begin
        bad++;
        $display("FAIL rotate_%0d: idx=%0d phase=%h wrap=%b drift=%0d want idx=%0d phase=%h wrap=%b drift=0",
                 i, a_if.phase_idx, a_if.phase, a_if.wrap, a_if.drift, i % 8, exp_ph, (i % 8 == 0));
      end
    end
    total++;
    if (wraps !== 2) begin
      bad++;
      $display("FAIL wrap_count: got %0d want 2", wraps);
    end
  endtask

  // adv at idx 3 -> 5; held adv ignored for 4 cycles; accepted again on the 5th.
  task automatic test_holdoff();
    int exp_idx [4] = '{6, 7, 0, 1};
    a_if.ld = 1; a_if.ld_idx = 3'd3;
    tick();
    a_if.ld = 0; a_if.adv = 1;
    tick();
    total++;
    if (a_if.phase_idx !== 3'd5 || a_if.corr_ack !== 1'b1 || a_if.drift !== 8'd1) begin
      bad++;
      $display("FAIL adv_accept: idx=%0d ack=%b drift=%0d want 5 1 1", a_if.phase_idx, a_if.corr_ack, a_if.drift);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (a_if.phase_idx !== 3'(exp_idx[i]) || a_if.corr_ack !== 1'b0 || a_if.drift !== 8'd1 ||
          a_if.wrap !== (exp_idx[i] == 0)) begin
        bad++;
        $display("FAIL holdoff_%0d: idx=%0d ack=%b wrap=%b drift=%0d want idx=%0d ack=0 drift=1",
                 i, a_if.phase_idx, a_if.corr_ack, a_if.wrap, a_if.drift, exp_idx[i]);
      end
    end
    tick();
    total++;
    if (a_if.phase_idx !== 3'd3 || a_if.corr_ack !== 1'b1 || a_if.drift !== 8'd2) begin
      bad++;
      $display("FAIL adv_reaccept: idx=%0d ack=%b drift=%0d want 3 1 2", a_if.phase_idx, a_if.corr_ack, a_if.drift);
    end
    a_if.adv = 0;
  endtask

  // ret at idx 7 holds without wrap; adv&ret together steps 1 with wrap and no ack.
  task automatic test_retard_and_both();
    a_if.ld = 1; a_if.ld_idx = 3'd7;
    tick();
    a_if.ld = 0; a_if.ret = 1;
    tick();
    total++;
    if (a_if.phase_idx !== 3'd7 || a_if.wrap !== 1'b0 || a_if.corr_ack !== 1'b1 || a_if.drift !== 8'd1) begin
      bad++;
      $display("FAIL ret_hold: idx=%0d wrap=%b ack=%b drift=%0d want 7 0 1 1",
               a_if.phase_idx, a_if.wrap, a_if.corr_ack, a_if.drift);
    end
    a_if.ret = 0; a_if.ld = 1; a_if.ld_idx = 3'd7;
    tick();
    a_if.ld = 0; a_if.adv = 1; a_if.ret = 1;
    tick();
    total++;
    if (a_if.phase_idx !== 3'd0 || a_if.phase !== 8'h01 || a_if.wrap !== 1'b1 ||
        a_if.corr_ack !== 1'b0 || a_if.drift !== 8'd1) begin
      bad++;
      $display("FAIL adv_and_ret: idx=%0d phase=%h wrap=%b ack=%b drift=%0d want 0 01 1 0 1",
               a_if.phase_idx, a_if.phase, a_if.wrap, a_if.corr_ack, a_if.drift);
    end
    a_if.adv = 0; a_if.ret = 0;
  endtask

  // en=0 freezes everything; ld beats rotation and discards that cycle's adv.
  task automatic test_enable_and_load_priority();
    a_if.en = 0; a_if.adv = 1;
    tick();
    tick();
    total++;
    if (a_if.phase_idx !== 3'd0 || a_if.corr_ack !== 1'b0 || a_if.wrap !== 1'b0 || a_if.drift !== 8'd1) begin
      bad++;
      $display("FAIL en_freeze: idx=%0d ack=%b wrap=%b drift=%0d want 0 0 0 1",
               a_if.phase_idx, a_if.corr_ack, a_if.wrap, a_if.drift);
    end
    a_if.en = 1; a_if.ld = 1; a_if.ld_idx = 3'd2;
    tick();
    total++;
    if (a_if.phase_idx !== 3'd2 || a_if.corr_ack !== 1'b0 || a_if.drift !== 8'd1) begin
      bad++;
      $display("FAIL ld_priority: idx=%0d ack=%b drift=%0d want 2 0 1", a_if.phase_idx, a_if.corr_ack, a_if.drift);
    end
    a_if.ld = 0;
    tick();
    total++;
    if (a_if.phase_idx !== 3'd4 || a_if.corr_ack !== 1'b1 || a_if.drift !== 8'd2) begin
      bad++;
      $display("FAIL adv_after_ld: idx=%0d ack=%b drift=%0d want 4 1 2", a_if.phase_idx, a_if.corr_ack, a_if.drift);
    end
    a_if.adv = 0; a_if.en = 0;
  endtask

  // N=6 modulo rotation, loads, and illegal load indices.
  task automatic test_n6_load();
    int exp_idx [7] = '{1, 2, 3, 4, 5, 0, 1};
    do_reset();
    b_if.en = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      total++;
      if (b_if.phase_idx !== 3'(exp_idx[i]) || b_if.phase !== (6'd1 << exp_idx[i]) ||
          b_if.wrap !== (exp_idx[i] == 0)) begin
        bad++;
        $display("FAIL n6_rotate_%0d: idx=%0d phase=%h wrap=%b want idx=%0d",
                 i, b_if.phase_idx, b_if.phase, b_if.wrap, exp_idx[i]);
      end
    end
    b_if.ld = 1; b_if.ld_idx = 3'd4;
    tick();
    total++;
    if (b_if.phase_idx !== 3'd4 || b_if.ld_err !== 1'b0 || b_if.wrap !== 1'b0) begin
      bad++;
      $display("FAIL n6_ld4: idx=%0d err=%b wrap=%b want 4 0 0", b_if.phase_idx, b_if.ld_err, b_if.wrap);
    end
    b_if.ld_idx = 3'd6;
    tick();
    total++;
    if (b_if.phase_idx !== 3'd5 || b_if.ld_err !== 1'b1 || b_if.wrap !== 1'b0) begin
      bad++;
      $display("FAIL n6_ld6: idx=%0d err=%b wrap=%b want 5 1 0", b_if.phase_idx, b_if.ld_err, b_if.wrap);
    end
    b_if.ld_idx = 3'd7;
    tick();
    total++;
    if (b_if.phase_idx !== 3'd0 || b_if.ld_err !== 1'b1 || b_if.wrap !== 1'b1) begin
      bad++;
      $display("FAIL n6_ld7: idx=%0d err=%b wrap=%b want 0 1 1", b_if.phase_idx, b_if.ld_err, b_if.wrap);
    end
    b_if.ld = 0;
    tick();
    total++;
    if (b_if.phase_idx !== 3'd1 || b_if.ld_err !== 1'b0) begin
      bad++;
      $display("FAIL n6_err_clear: idx=%0d err=%b want 1 0", b_if.phase_idx, b_if.ld_err);
    end
    b_if.en = 0; b_if.ld = 1; b_if.ld_idx = 3'd5;
    tick();
    total++;
    if (b_if.phase_idx !== 3'd5 || b_if.phase !== 6'h20) begin
      bad++;
      $display("FAIL n6_ld_en0: idx=%0d phase=%h want 5 20", b_if.phase_idx, b_if.phase);
    end
    b_if.ld = 0; b_if.en = 1; b_if.adv = 1;
    tick();
    total++;
    if (b_if.phase_idx !== 3'd1 || b_if.wrap !== 1'b1 || b_if.corr_ack !== 1'b1) begin
      bad++;
      $display("FAIL n6_adv_wrap: idx=%0d wrap=%b ack=%b want 1 1 1", b_if.phase_idx, b_if.wrap, b_if.corr_ack);
    end
    b_if.adv = 0; b_if.en = 0;
  endtask

  // DRIFT_W=3, HOLDOFF=0: held adv saturates at +3, held ret at -4 with idx frozen.
  task automatic test_drift_saturation();
    int exp_idx [6]    = '{2, 4, 6, 0, 2, 4};
    int exp_up [6]     = '{1, 2, 3, 3, 3, 3};
    int exp_dn [10]    = '{2, 1, 0, -1, -2, -3, -4, -4, -4, -4};
    logic [2:0] e_d;
    do_reset();
    c_if.en = 1; c_if.adv = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      e_d = 3'(exp_up[i]);
      total++;
      if (c_if.phase_idx !== 3'(exp_idx[i]) || c_if.drift !== e_d || c_if.corr_ack !== 1'b1) begin
        bad++;
        $display("FAIL sat_up_%0d: idx=%0d drift=%b ack=%b want idx=%0d drift=%b ack=1",
                 i, c_if.phase_idx, c_if.drift, c_if.corr_ack, exp_idx[i], e_d);
      end
    end
    c_if.adv = 0; c_if.ret = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      e_d = 3'(exp_dn[i]);
      total++;
      if (c_if.phase_idx !== 3'd4 || c_if.drift !== e_d || c_if.wrap !== 1'b0) begin
        bad++;
        $display("FAIL sat_dn_%0d: idx=%0d drift=%b wrap=%b want idx=4 drift=%b wrap=0",
                 i, c_if.phase_idx, c_if.drift, c_if.wrap, e_d);
      end
    end
    c_if.ret = 0; c_if.en = 0;
  endtask

  // N=2: a step of 2 leaves the index unchanged but still flags wrap.
  task automatic test_n2_step2();
    do_reset();
    d_if.en = 1; d_if.adv = 1;
    tick();
    total++;
    if (d_if.phase_idx !== 1'b0 || d_if.phase !== 2'b01 || d_if.wrap !== 1'b1 || d_if.corr_ack !== 1'b1) begin
      bad++;
      $display("FAIL n2_adv0: idx=%0d phase=%b wrap=%b ack=%b want 0 01 1 1",
               d_if.phase_idx, d_if.phase, d_if.wrap, d_if.corr_ack);
    end
    d_if.adv = 0;
    tick();
    d_if.adv = 1;
    tick();
    total++;
    if (d_if.phase_idx !== 1'b1 || d_if.phase !== 2'b10 || d_if.wrap !== 1'b1 || d_if.drift !== 8'd2) begin
      bad++;
      $display("FAIL n2_adv1: idx=%0d phase=%b wrap=%b drift=%0d want 1 10 1 2",
               d_if.phase_idx, d_if.phase, d_if.wrap, d_if.drift);
    end
    d_if.adv = 0; d_if.en = 0;
  endtask

  // Async reset mid-holdoff at idx 5, drift 2; the first adv after reset is accepted.
  task automatic test_reset_mid_holdoff();
    do_reset();
    a_if.en = 1; a_if.ld = 1; a_if.ld_idx = 3'd1;
    tick();
    a_if.ld = 0; a_if.adv = 1;
    tick();
    a_if.adv = 0; a_if.en = 0;
    repeat (4) tick();
    a_if.en = 1; a_if.adv = 1;
    tick();
    total++;
    if (a_if.phase_idx !== 3'd5 || a_if.drift !== 8'd2 || a_if.corr_ack !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: idx=%0d drift=%0d ack=%b want 5 2 1", a_if.phase_idx, a_if.drift, a_if.corr_ack);
    end
    a_if.adv = 0; a_if.en = 0;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (a_if.phase_idx !== 3'd0 || a_if.phase !== 8'h01 || a_if.drift !== 8'd0 || a_if.corr_ack !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: idx=%0d phase=%h drift=%0d ack=%b want 0 01 0 0",
               a_if.phase_idx, a_if.phase, a_if.drift, a_if.corr_ack);
    end
    tick();
    rst = 1'b0;
    a_if.en = 1; a_if.adv = 1;
    tick();
    total++;
    if (a_if.phase_idx !== 3'd2 || a_if.corr_ack !== 1'b1 || a_if.drift !== 8'd1) begin
      bad++;
      $display("FAIL post_reset_adv: idx=%0d ack=%b drift=%0d want 2 1 1", a_if.phase_idx, a_if.corr_ack, a_if.drift);
    end
    a_if.adv = 0; a_if.en = 0;
  endtask

  initial begin
    idle_all();
    test_reset_and_rotate();
    test_holdoff();
    test_retard_and_both();
    test_enable_and_load_priority();
    test_n6_load();
    test_drift_saturation();
    test_n2_step2();
    test_reset_mid_holdoff();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
